spi_reg_ctrl: RTL



---
 rtl/spi_reg_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// Command/register-access sequencer behind an SPI slave PHY: decodes a
// command byte and an address byte, then bursts register writes or reads.
module spi_reg_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              msg_start,
  input  logic              msg_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              err,
  output logic [6:0]        msg_cnt
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, ERR} state_t;

  state_t state_reg, state_next;
  logic   rw_reg, ai_reg;
  logic   re_pend_reg, rd_cap_reg;

  // A byte coincident with msg_start belongs to no message.
  logic rx_act, cmd_ok, cmd_hit, addr_hit, wr_hit, rd_hit, abort;
  assign rx_act   = rx_valid && !msg_start;
  assign cmd_ok   = (rx_data[5:0] == 6'd0);
  assign cmd_hit  = rx_act && !msg_end && (state_reg == CMD);
  assign addr_hit = rx_act && !msg_end && (state_reg == ADDR);
  assign wr_hit   = rx_act && (state_reg == WDATA);
  assign rd_hit   = rx_act && !msg_end && (state_reg == RDATA);
  assign abort    = msg_start || msg_end;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (msg_start) begin
      state_next = CMD;
    end else if (msg_end) begin
      state_next = IDLE;
    end else if (rx_valid) begin
      case (state_reg)
        CMD:     state_next = cmd_ok ? ADDR : ERR;
        ADDR:    state_next = rw_reg ? RDATA : WDATA;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_data     <= 8'h00;
      reg_addr    <= '0;
      reg_wdata   <= 8'h00;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      err         <= 1'b0;
      msg_cnt     <= 7'd0;
      rw_reg      <= 1'b0;
      ai_reg      <= 1'b0;
      re_pend_reg <= 1'b0;
      rd_cap_reg  <= 1'b0;
    end else begin
      reg_we <= wr_hit;
      if (wr_hit) reg_wdata <= rx_data;

      // Address moves after a write strobe, or ahead of a burst re-read.
      if (addr_hit)
        reg_addr <= rx_data[ADDR_W-1:0];
      else if (rd_hit && ai_reg)
        reg_addr <= reg_addr + ADDR_W'(1);
      else if (reg_we)
        reg_addr <= reg_addr + ADDR_W'(ai_reg);

      re_pend_reg <= rd_hit;
      reg_re      <= !abort && ((addr_hit && rw_reg) || re_pend_reg);
      rd_cap_reg  <= reg_re && !abort;

      if (msg_start)
        tx_data <= {err, msg_cnt};
      else if (cmd_hit)
        tx_data <= 8'h00;
      else if (rd_cap_reg)
        tx_data <= reg_rdata;

      if (msg_start)
        err <= 1'b0;
      else if (cmd_hit && !cmd_ok)
        err <= 1'b1;

      if (cmd_hit && cmd_ok) begin
        msg_cnt <= msg_cnt + 7'd1;
        rw_reg  <= rx_data[7];
        ai_reg  <= rx_data[6];
      end
    end
  end

endmodule
